// File: rtl/fc2_sequencer.sv
// FC2 layer sequencer: walks each output neuron over all FC1 activations, drains the MAC
// pipeline, shifts each result into the output FIFO and hands the full vector downstream.
module fc2_sequencer #(
  parameter int unsigned NUM_INPUTS  = 84,
  parameter int unsigned NUM_OUTPUTS = 10,
  parameter int unsigned MAC_LATENCY = 3,
  parameter int unsigned ADDR_IFM    = $clog2(NUM_INPUTS),
  parameter int unsigned ADDR_WM     = $clog2(NUM_INPUTS * NUM_OUTPUTS),
  parameter int unsigned ADDR_NEURON = $clog2(NUM_OUTPUTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   out_ready,
  output logic [ADDR_IFM-1:0]    ifm_addr,
  output logic [ADDR_WM-1:0]     wm_addr,
  output logic [ADDR_NEURON-1:0] neuron_idx,
  output logic                   mac_enable,
  output logic                   mac_first,
  output logic                   fifo_enable,
  output logic                   busy,
  output logic                   out_valid,
  output logic                   done
);

  localparam int unsigned DrainW = $clog2(MAC_LATENCY + 2);
  localparam logic [ADDR_IFM-1:0]    LastIn     = ADDR_IFM'(NUM_INPUTS - 1);
  localparam logic [ADDR_NEURON-1:0] LastNeuron = ADDR_NEURON'(NUM_OUTPUTS - 1);
  localparam logic [DrainW-1:0]      LastDrain  = DrainW'(MAC_LATENCY);

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StShift, StHold} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_IFM-1:0]    i_q, i_d;
  logic [ADDR_WM-1:0]     wm_q, wm_d;
  logic [ADDR_NEURON-1:0] neuron_q, neuron_d;
  logic [DrainW-1:0]      drain_q, drain_d;
  logic                   mac_en_q, mac_en_d;
  logic                   mac_first_q, mac_first_d;
  logic                   done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      i_q         <= '0;
      wm_q        <= '0;
      neuron_q    <= '0;
      drain_q     <= '0;
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      wm_q        <= wm_d;
      neuron_q    <= neuron_d;
      drain_q     <= drain_d;
      mac_en_q    <= mac_en_d;
      mac_first_q <= mac_first_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    wm_d        = wm_q;
    neuron_d    = neuron_q;
    drain_d     = drain_q;
    mac_en_d    = 1'b0;
    mac_first_d = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A start coinciding with the done pulse belongs to the finished pass.
        if (start && !done_q) begin
          state_d  = StRun;
          i_d      = '0;
          wm_d     = '0;
          neuron_d = '0;
        end
      end
      StRun: begin
        mac_en_d    = 1'b1;
        mac_first_d = (i_q == '0);
        // Running counter lands on the next neuron's base address after the last input.
        wm_d        = wm_q + 1'b1;
        if (i_q == LastIn) begin
          i_d     = '0;
          drain_d = '0;
          state_d = StDrain;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == LastDrain) begin
          state_d = StShift;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StShift: begin
        if (neuron_q != LastNeuron) begin
          neuron_d = neuron_q + 1'b1;
          state_d  = StRun;
        end else begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ifm_addr    = i_q;
  assign wm_addr     = wm_q;
  assign neuron_idx  = neuron_q;
  assign mac_enable  = mac_en_q;
  assign mac_first   = mac_first_q;
  assign fifo_enable = (state_q == StShift);
  assign busy        = (state_q != StIdle);
  assign out_valid   = (state_q == StHold);
  assign done        = done_q;

endmodule

// File: tb/tb_fc2_sequencer.sv
// Self-checking bench for fc2_sequencer: a cycle-position model derived from the pass
// period P = N + L + 2 predicts every output under randomized start/out_ready stimulus.
module tb_fc2_sequencer;

  localparam int N  = 84;
  localparam int L  = 3;
  localparam int M  = 10;
  localparam int P  = N + L + 2;
  localparam int MP = M * P;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       out_ready;
  logic [6:0] ifm_addr;
  logic [9:0] wm_addr;
  logic [3:0] neuron_idx;
  logic       mac_enable;
  logic       mac_first;
  logic       fifo_enable;
  logic       busy;
  logic       out_valid;
  logic       done;

  always #5 clk = ~clk;

  fc2_sequencer #(
    .NUM_INPUTS (N),
    .NUM_OUTPUTS(M),
    .MAC_LATENCY(L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .out_ready  (out_ready),
    .ifm_addr   (ifm_addr),
    .wm_addr    (wm_addr),
    .neuron_idx (neuron_idx),
    .mac_enable (mac_enable),
    .mac_first  (mac_first),
    .fifo_enable(fifo_enable),
    .busy       (busy),
    .out_valid  (out_valid),
    .done       (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: mc is the cycle position within a pass (0 = idle, 1..MP active, >MP holding).
  int mc       = 0;
  bit mdone    = 1'b0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int fifo_cnt = 0;
  bit ov_seen  = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, pos %0d)", tag, got, exp, cyc, mc);
    end
  endtask

  task automatic check_model();
    bit act;
    int k;
    int r;
    act = (mc >= 1) && (mc <= MP);
    k   = act ? (mc - 1) / P : 0;
    r   = act ? (mc - 1) % P + 1 : 0;
    check("busy", int'(busy), int'(mc != 0));
    check("ifm_addr", int'(ifm_addr), (act && r <= N) ? r - 1 : 0);
    if (act && r <= N) check("wm_addr", int'(wm_addr), k * N + r - 1);
    if (act) check("neuron_idx", int'(neuron_idx), k);
    check("mac_enable", int'(mac_enable), int'(act && r >= 2 && r <= N + 1));
    check("mac_first", int'(mac_first), int'(act && r == 2));
    check("fifo_enable", int'(fifo_enable), int'(act && r == P));
    check("out_valid", int'(out_valid), int'(mc > MP));
    check("done", int'(done), int'(mdone));
    if (out_valid && !ov_seen) begin
      ov_seen = 1'b1;
      check("ov_latency", cyc - acc_cyc, MP + 1);
    end
  endtask

  // Check the current cycle, drive inputs for the coming edge, advance the model.
  task automatic step(input logic st, input logic rdy);
    bit nxt_done;
    check_model();
    if (fifo_enable) fifo_cnt++;
    start     = st;
    out_ready = rdy;
    nxt_done  = (mc > MP) && rdy;
    if (mc == 0) begin
      if (st && !mdone) begin
        mc       = 1;
        acc_cyc  = cyc;
        fifo_cnt = 0;
        ov_seen  = 1'b0;
      end
    end else if (mc <= MP) begin
      mc++;
    end else if (rdy) begin
      check("fifo_per_pass", fifo_cnt, M);
      mc = 0;
    end
    mdone = nxt_done;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_to_hold(input bit rnd_start, input bit rnd_ready);
    for (int g = 0; g < MP + 5 && mc <= MP; g++) begin
      step(rnd_start ? 1'($urandom_range(0, 1)) : 1'b0,
           rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0);
    end
  endtask

  initial begin
    #500us;
    $display("FAIL timeout: got no finish expected finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    #2;
    check_model();
    @(negedge clk);
    check_model();
    rst = 1'b0;

    // Clean pass with out_ready already high on HOLD entry.
    step(1'b1, 1'b1);
    run_to_hold(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Backpressure and stray starts during RUN and HOLD.
    step(1'b1, 1'b0);
    run_to_hold(1'b1, 1'b1);
    for (int j = 0; j < 20; j++) step(1'($urandom_range(0, 1)), 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Async reset between edges while neuron 5 is in RUN.
    step(1'b1, 1'b0);
    begin
      int stop_at;
      stop_at = 5 * P + 1 + $urandom_range(0, N - 1);
      for (int g = 0; g < MP && mc < stop_at; g++) step(1'($urandom_range(0, 1)), 1'b0);
    end
    check("pre_reset_neuron", int'(neuron_idx), 5);
    #2;
    rst   = 1'b1;
    mc    = 0;
    mdone = 1'b0;
    #1;
    check_model();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_model();
    rst = 1'b0;
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    run_to_hold(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Start held high: each new pass begins the cycle after done.
    for (int j = 0; j < 2 * (MP + 3); j++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    for (int g = 0; g < MP + 5 && mc != 0; g++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fc2_sequencer.md
Name: fc2_sequencer

Overview:
- Sequences the FC2 (final classifier) layer: walks every output neuron over all FC1 activations and issues IFM/weight read addresses plus MAC enables.
- Waits for the MAC pipeline to drain, then pulses fifo_enable to shift each finished neuron result into the 10-output FC2 shift register.
- After the last neuron, presents out_valid with a valid/ready handshake to the argmax/classification stage.

Parameters:
- NUM_INPUTS, 84, FC1 activations per neuron (N).
- NUM_OUTPUTS, 10, FC2 neurons; must equal the FC2 output FIFO depth.
- MAC_LATENCY, 3, cycles from mac_enable to the accumulator result being stable (L, ≥1).
- ADDR_IFM, $clog2(NUM_INPUTS), IFM address width.
- ADDR_WM, $clog2(NUM_INPUTS*NUM_OUTPUTS), weight address width.
- ADDR_NEURON, $clog2(NUM_OUTPUTS), neuron index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a layer pass; sampled only in IDLE.
- out_ready  in  1  downstream accepts the 10 parallel results.
- ifm_addr  out  ADDR_IFM  activation read address (memory latency 1 cycle).
- wm_addr  out  ADDR_WM  weight read address = neuron*N + i.
- neuron_idx  out  ADDR_NEURON  current neuron, also used as bias address.
- mac_enable  out  1  accumulate this cycle's memory outputs.
- mac_first  out  1  with the first mac_enable of a neuron; accumulator loads instead of adding.
- fifo_enable  out  1  one-cycle shift strobe into the FC2 output FIFO.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  all NUM_OUTPUTS results present in the FIFO.
- done  out  1  one-cycle pulse on handshake completion.

Behaviour:
- Reset (async, any state): state=IDLE; all counters, addresses, neuron_idx and every output = 0; pending pipeline enables are discarded.
- States: IDLE, RUN, DRAIN, SHIFT, HOLD.
- IDLE: start=1 → RUN next cycle; neuron=0, i=0, wm_addr=0. start outside IDLE is ignored.
- RUN, N cycles: ifm_addr=i, wm_addr increments by 1 each cycle as a running counter (no multiplier). i=N-1 → DRAIN with i cleared.
- mac_enable = issue-valid delayed 1 cycle. mac_first = delayed (RUN && i==0). mac_enable therefore extends 1 cycle into DRAIN.
- DRAIN, L+1 cycles (counter), then SHIFT.
- SHIFT, 1 cycle: fifo_enable=1.
  - neuron<NUM_OUTPUTS-1 → neuron++, RUN; wm_addr continues from neuron*N.
  - Otherwise → HOLD.
- HOLD: out_valid=1, held until out_valid&&out_ready. On that cycle, out_valid drops next cycle, done=1 for one cycle, state → IDLE.
  - out_ready high on HOLD entry completes the handshake in the first HOLD cycle.
- Timing, with start sampled at edge 0:
  - Neuron k RUN occupies cycles k·P+1 … k·P+N, where P = N+L+2.
  - SHIFT for neuron k occurs at cycle (k+1)·P.
  - out_valid first high at NUM_OUTPUTS·P+1.
- fifo_enable is never asserted outside SHIFT: exactly NUM_OUTPUTS pulses per pass. Neuron 0's result ends up at FIFO output 1, neuron 9's at output 10.
- busy=0 only in IDLE. done and start may coincide with IDLE entry. start during the done cycle is ignored; it is accepted the following cycle.
- Reset during RUN/DRAIN/SHIFT/HOLD: no further fifo_enable, done, or out_valid until a new start.

Test Plan:
- Defaults (N=84, L=3, P=89): start pulse at cycle 0 → 10 fifo_enable pulses at cycles 89,178,…,890; out_valid rises at 891; out_ready=1 there gives done at 892 and busy=0 at 892.
- N=4, L=2, NUM_OUTPUTS=10:
  - neuron 2: wm_addr sequence 8,9,10,11; ifm_addr 0,1,2,3.
  - mac_enable high for exactly 4 cycles per neuron, 1 cycle after the addresses; mac_first on the first of them only.
- Backpressure: out_ready low for 20 cycles in HOLD → out_valid stays 1, no extra fifo_enable, done only after out_ready rises.
- Ignored start: start asserted during RUN and during HOLD → no restart, counters unaffected; total fifo_enable count still 10.
- Async reset asserted mid-RUN of neuron 5 (between clock edges) → outputs immediately 0, state IDLE. A new start then runs the full 10 neurons from neuron 0 and wm_addr 0.
- Back-to-back passes: start held high continuously → second pass begins the cycle after done; cycle counts identical to the first pass.
